// File: rtl/sum_diff_accum.sv
// rtl/sum_diff_accum.sv - accumulates blocks of COUNT sum/diff samples with a valid/ready handshake on both sides
// The result is held in FULL until consumed; a sample arriving with the consume starts the next block with no bubble.
module sum_diff_accum #(
  parameter int WIDTH = 2,
  parameter int COUNT = 4,
  parameter int ACC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] diff_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_acc,
  output logic [ACC_W-1:0] diff_acc,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ST_ACC, ST_FULL} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0] r_sum, r_diff, w_sum_nxt, w_diff_nxt;
  logic [ACC_W-1:0] w_sum_ext, w_diff_ext;

  assign w_sum_ext  = ACC_W'(sum_in);
  assign w_diff_ext = ACC_W'(diff_in);
  assign sum_acc    = r_sum;
  assign diff_acc   = r_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_diff  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
      r_diff  <= w_diff_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_diff_nxt  = r_diff;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACC: begin
        if (in_valid) begin
          w_sum_nxt  = r_sum + w_sum_ext;
          w_diff_nxt = r_diff + w_diff_ext;
          if (r_cnt == LAST) begin
            w_state_nxt = ST_FULL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          // A sample taken together with the consume seeds the next block.
          if (in_valid) begin
            w_sum_nxt  = w_sum_ext;
            w_diff_nxt = w_diff_ext;
            if (COUNT == 1) begin
              w_state_nxt = ST_FULL;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_ACC;
              w_cnt_nxt   = CNT_W'(1);
            end
          end else begin
            w_sum_nxt   = '0;
            w_diff_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ACC;
          end
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

endmodule
